// File: rtl/i2c_slave_regs.sv
// I2C target with a 2**ADDR_W x 8 register bank: pointer write, burst
// write/read with wrapping auto-increment, and a combinational debug port.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         ADDR_W     = 4,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               sda,
    inout  wire               scl,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_stb,
    output logic              busy,
    output logic              addr_hit,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK,
        S_WR, S_W_ACK, S_RD, S_M_ACK, S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        scl_q, sda_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ph_q, ph_d;
    logic              rw_q, rw_d;
    logic              drv_q, drv_d;
    logic              busy_q, busy_d;
    logic              hit_q, hit_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rd_stb_q, rd_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              we;
    logic [7:0]        bank_q [2**ADDR_W];

    logic       scl_rise, scl_fall, scl_hi;
    logic       start_c, stop_c;
    logic [7:0] sh_in, rd_byte;

    // [1:0] synchronize, [2] is the delayed copy used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign scl_hi   = scl_q[1] & scl_q[2];
    assign start_c  = scl_hi & ~sda_q[1] & sda_q[2];
    assign stop_c   = scl_hi & sda_q[1] & ~sda_q[2];
    assign sh_in    = {sh_q[6:0], sda_q[1]};
    assign rd_byte  = bank_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        ph_d      = ph_q;
        rw_d      = rw_q;
        drv_d     = drv_q;
        busy_d    = busy_q;
        hit_d     = hit_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we        = 1'b0;
        if (stop_c) begin
            state_d = S_IDLE;
            drv_d   = 1'b0;
            busy_d  = 1'b0;
            hit_d   = 1'b0;
            ph_d    = 1'b0;
        end else if (start_c) begin
            state_d = S_ADDR;
            cnt_d   = 3'd7;
            busy_d  = 1'b1;
            hit_d   = 1'b0;
            drv_d   = 1'b0;
            ph_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        if (sh_in[7:1] == SLAVE_ADDR) begin
                            state_d = S_A_ACK;
                            rw_d    = sh_in[0];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_A_ACK: if (scl_fall) begin
                    if (!ph_q) begin
                        drv_d = 1'b1;
                        ph_d  = 1'b1;
                        hit_d = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        cnt_d = 3'd7;
                        if (rw_q) begin
                            sh_d     = rd_byte;
                            drv_d    = ~rd_byte[7];
                            rd_stb_d = 1'b1;
                            state_d  = S_RD;
                        end else begin
                            drv_d   = 1'b0;
                            state_d = S_PTR;
                        end
                    end
                end
                S_PTR: if (scl_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        ptr_d   = sh_in[ADDR_W-1:0];
                        state_d = S_P_ACK;
                    end
                end
                S_WR: if (scl_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) state_d = S_W_ACK;
                end
                S_P_ACK, S_W_ACK: if (scl_fall) begin
                    if (!ph_q) begin
                        drv_d = 1'b1;
                        ph_d  = 1'b1;
                        if (state_q == S_W_ACK) begin
                            we        = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sh_q;
                            ptr_d     = ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        ph_d    = 1'b0;
                        drv_d   = 1'b0;
                        cnt_d   = 3'd7;
                        state_d = S_WR;
                    end
                end
                S_RD: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        drv_d   = 1'b0;
                        ph_d    = 1'b0;
                        state_d = S_M_ACK;
                    end else begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        drv_d = ~sh_q[6];
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                // ptr advances on the master ACK; next byte drives on the fall
                S_M_ACK: begin
                    if (scl_rise && !ph_q) begin
                        if (sda_q[1]) begin
                            state_d = S_WAIT;
                        end else begin
                            ph_d  = 1'b1;
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end else if (scl_fall && ph_q) begin
                        ph_d     = 1'b0;
                        sh_d     = rd_byte;
                        drv_d    = ~rd_byte[7];
                        rd_stb_d = 1'b1;
                        cnt_d    = 3'd7;
                        state_d  = S_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd7;
            sh_q      <= 8'h00;
            ptr_q     <= '0;
            ph_q      <= 1'b0;
            rw_q      <= 1'b0;
            drv_q     <= 1'b0;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            ph_q      <= ph_d;
            rw_q      <= rw_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            hit_q     <= hit_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) bank_q[i] <= RST_VAL;
        end else if (we) begin
            bank_q[ptr_q] <= sh_q;
        end
    end

    assign sda      = drv_q ? 1'b0 : 1'bz;
    assign scl      = 1'bz;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_stb   = rd_stb_q;
    assign busy     = busy_q;
    assign addr_hit = hit_q;
    assign dbg_data = bank_q[dbg_addr];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master model, a write scoreboard
// fed by the stimulus and drained on wr_stb, and queued read expectations.
module tb_i2c_slave_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_sda = 1'b1;
    logic       m_scl = 1'b1;
    wire        sda, scl;
    logic       wr_stb, rd_stb, busy, addr_hit;
    logic [3:0] wr_addr, dbg_addr;
    logic [7:0] wr_data, dbg_data;

    always #5 clk = ~clk;

    assign sda = m_sda ? 1'bz : 1'b0;
    assign scl = m_scl ? 1'bz : 1'b0;
    pullup(sda);
    pullup(scl);

    i2c_slave_regs dut (
        .clk(clk), .rst(rst), .sda(sda), .scl(scl),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .busy(busy), .addr_hit(addr_hit),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t        wr_e;
    logic [7:0] mbank[16];
    logic [3:0] mptr;

    // scoreboard drain: every wr_stb must match the oldest expected write
    always @(negedge clk) begin
        if (rd_stb) n_rd++;
        if (wr_stb) begin
            n_wr++;
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected got a=%0d d=%h want none",
                         wr_addr, wr_data);
            end else begin
                wr_e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== wr_e) begin
                    n_err++;
                    $display("FAIL wr_event got a=%0d d=%h want a=%0d d=%h",
                             wr_addr, wr_data, wr_e.a, wr_e.d);
                end
            end
        end
    end

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_bit(input logic o, output logic i);
        m_sda = o;
        qw();
        m_scl = 1'b1;
        qw();
        i = sda;
        qw();
        m_scl = 1'b0;
        qw();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        qw();
        m_scl = 1'b1;
        qw();
        m_sda = 1'b0;
        qw();
        m_scl = 1'b0;
        qw();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        qw();
        m_scl = 1'b1;
        qw();
        m_sda = 1'b1;
        qw();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], x);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, x);
            b[i] = x;
        end
        i2c_bit(mack, x);
    endtask

    task automatic push_wr(input logic [7:0] d);
        exp_wr.push_back({mptr, d});
        mbank[mptr] = d;
        mptr = mptr + 4'd1;
    endtask

    task automatic wr_txn(input logic [7:0] p, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2,
                          input int n, output int nk);
        logic       a;
        logic [7:0] dv[3];
        dv = '{d0, d1, d2};
        nk = 0;
        i2c_start();
        wr_byte(8'hA0, a);
        nk += int'(a);
        wr_byte(p, a);
        nk += int'(a);
        mptr = p[3:0];
        for (int k = 0; k < n; k++) begin
            push_wr(dv[k]);
            wr_byte(dv[k], a);
            nk += int'(a);
        end
        i2c_stop();
        qw();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL rst_sda got %b want 1", sda);
        end
        n_cmp++;
        if ({busy, addr_hit, wr_stb, rd_stb} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_flags got %b want 0000",
                     {busy, addr_hit, wr_stb, rd_stb});
        end
        n_cmp++;
        if ({wr_addr, wr_data} !== 12'h0) begin
            n_err++;
            $display("FAIL rst_wr got %h want 000", {wr_addr, wr_data});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mbank[i] = 8'h00;
            dbg_addr = 4'(i);
            #1;
            n_cmp++;
            if (dbg_data !== 8'h00) begin
                n_err++;
                $display("FAIL rst_bank[%0d] got %h want 00", i, dbg_data);
            end
        end
        mptr = 4'd0;
    endtask

    task automatic test_write();
        logic a;
        int   w0 = n_wr;
        i2c_start();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL wr_busy got %b want 1", busy);
        end
        wr_byte(8'hA0, a);
        n_cmp++;
        if (a !== 1'b0) begin
            n_err++; $display("FAIL wr_addr_ack got %b want 0", a);
        end
        n_cmp++;
        if (addr_hit !== 1'b1) begin
            n_err++; $display("FAIL wr_hit got %b want 1", addr_hit);
        end
        wr_byte(8'h03, a);
        mptr = 4'd3;
        n_cmp++;
        if (a !== 1'b0) begin
            n_err++; $display("FAIL wr_ptr_ack got %b want 0", a);
        end
        push_wr(8'hA5);
        wr_byte(8'hA5, a);
        n_cmp++;
        if (a !== 1'b0) begin
            n_err++; $display("FAIL wr_data_ack got %b want 0", a);
        end
        i2c_stop();
        qw();
        n_cmp++;
        if ({busy, addr_hit} !== 2'b00) begin
            n_err++;
            $display("FAIL wr_stop got %b want 00", {busy, addr_hit});
        end
        n_cmp++;
        if (n_wr - w0 !== 1 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL wr_count got %0d left %0d want 1 left 0",
                     n_wr - w0, exp_wr.size());
        end
        dbg_addr = 4'd3;
        #1;
        n_cmp++;
        if (dbg_data !== 8'hA5) begin
            n_err++; $display("FAIL wr_bank3 got %h want a5", dbg_data);
        end
    endtask

    task automatic test_burst_wrap();
        int nk;
        int w0 = n_wr;
        wr_txn(8'h0E, 8'h11, 8'h22, 8'h33, 3, nk);
        n_cmp++;
        if (nk != 0) begin
            n_err++; $display("FAIL burst_acks got %0d nacks want 0", nk);
        end
        n_cmp++;
        if (n_wr - w0 !== 3 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL burst_count got %0d left %0d want 3 left 0",
                     n_wr - w0, exp_wr.size());
        end
        for (int i = 0; i < 3; i++) begin
            dbg_addr = 4'(14 + i);
            #1;
            n_cmp++;
            if (dbg_data !== mbank[dbg_addr]) begin
                n_err++;
                $display("FAIL burst_bank[%0d] got %h want %h",
                         dbg_addr, dbg_data, mbank[dbg_addr]);
            end
        end
    endtask

    task automatic test_random_read();
        logic       a;
        logic [7:0] b, e;
        int         nk;
        int         r0;
        wr_txn(8'h04, 8'h3C, 8'hC3, 8'h00, 2, nk);
        r0 = n_rd;
        i2c_start();
        wr_byte(8'hA0, a);
        nk += int'(a);
        wr_byte(8'h03, a);
        nk += int'(a);
        mptr = 4'd3;
        i2c_start();
        wr_byte(8'hA1, a);
        nk += int'(a);
        n_cmp++;
        if (nk != 0) begin
            n_err++; $display("FAIL rr_acks got %0d nacks want 0", nk);
        end
        exp_rd.push_back(mbank[mptr]);
        rd_byte(1'b0, b);
        e = exp_rd.pop_front();
        n_cmp++;
        if (b !== e) begin
            n_err++; $display("FAIL rr_byte0 got %h want %h", b, e);
        end
        mptr = mptr + 4'd1;
        exp_rd.push_back(mbank[mptr]);
        rd_byte(1'b1, b);
        e = exp_rd.pop_front();
        n_cmp++;
        if (b !== e) begin
            n_err++; $display("FAIL rr_byte1 got %h want %h", b, e);
        end
        qw();
        n_cmp++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL rr_release got %b want 1", sda);
        end
        i2c_stop();
        qw();
        n_cmp++;
        if (n_rd - r0 !== 2) begin
            n_err++; $display("FAIL rr_rdstb got %0d want 2", n_rd - r0);
        end
    endtask

    task automatic test_mismatch();
        logic a;
        int   w0 = n_wr;
        i2c_start();
        wr_byte(8'hA2, a);
        n_cmp++;
        if (a !== 1'b1) begin
            n_err++; $display("FAIL mm_nack got %b want 1", a);
        end
        n_cmp++;
        if ({busy, addr_hit} !== 2'b10) begin
            n_err++;
            $display("FAIL mm_flags got %b want 10", {busy, addr_hit});
        end
        wr_byte(8'h00, a);
        n_cmp++;
        if (a !== 1'b1) begin
            n_err++; $display("FAIL mm_ignored got %b want 1", a);
        end
        i2c_stop();
        qw();
        n_cmp++;
        if (busy !== 1'b0 || n_wr != w0) begin
            n_err++;
            $display("FAIL mm_end busy %b writes %0d want 0 0",
                     busy, n_wr - w0);
        end
    endtask

    task automatic test_abort();
        logic       a, x;
        logic [7:0] b, e;
        int         nk = 0;
        int         w0 = n_wr;
        logic [3:0] nib = 4'b1010;
        i2c_start();
        wr_byte(8'hA0, a);
        nk += int'(a);
        wr_byte(8'h05, a);
        nk += int'(a);
        mptr = 4'd5;
        for (int i = 3; i >= 0; i--) i2c_bit(nib[i], x);
        i2c_stop();
        qw();
        n_cmp++;
        if (busy !== 1'b0 || n_wr != w0) begin
            n_err++;
            $display("FAIL ab_end busy %b writes %0d want 0 0",
                     busy, n_wr - w0);
        end
        i2c_start();
        wr_byte(8'hA1, a);
        nk += int'(a);
        n_cmp++;
        if (nk != 0) begin
            n_err++; $display("FAIL ab_acks got %0d nacks want 0", nk);
        end
        exp_rd.push_back(mbank[mptr]);
        rd_byte(1'b1, b);
        e = exp_rd.pop_front();
        n_cmp++;
        if (b !== e) begin
            n_err++; $display("FAIL ab_ptr_byte got %h want %h", b, e);
        end
        i2c_stop();
        qw();
    endtask

    task automatic test_reset_mid_rd();
        logic a;
        int   nk = 0;
        i2c_start();
        wr_byte(8'hA0, a);
        nk += int'(a);
        wr_byte(8'h00, a);
        nk += int'(a);
        i2c_start();
        wr_byte(8'hA1, a);
        nk += int'(a);
        n_cmp++;
        if (nk != 0 || sda !== mbank[0][7]) begin
            n_err++;
            $display("FAIL rm_drive got nacks %0d sda %b want 0 %b",
                     nk, sda, mbank[0][7]);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL rm_release got %b want 1", sda);
        end
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, addr_hit} !== 2'b00) begin
            n_err++;
            $display("FAIL rm_flags got %b want 00", {busy, addr_hit});
        end
        for (int i = 0; i < 16; i++) begin
            mbank[i] = 8'h00;
            dbg_addr = 4'(i);
            #1;
            n_cmp++;
            if (dbg_data !== mbank[i]) begin
                n_err++;
                $display("FAIL rm_bank[%0d] got %h want %h",
                         i, dbg_data, mbank[i]);
            end
        end
    endtask

    initial begin
        dbg_addr = 4'd0;
        test_reset();
        test_write();
        test_burst_wrap();
        test_random_read();
        test_mismatch();
        test_abort();
        test_reset_mid_rd();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
